// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball quadrature emulator: speed codes,
// Gray phase table, saturating add and backlog-dependent step period.
package trackball_pkg;

  localparam logic [1:0] SPEED_QUARTER = 2'd0;
  localparam logic [1:0] SPEED_HALF    = 2'd1;
  localparam logic [1:0] SPEED_X1      = 2'd2;
  localparam logic [1:0] SPEED_X2      = 2'd3;

  // (A,B) per phase index; a positive step walks the table upward
  localparam logic [1:0] GRAY_PHASE [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct packed {
    logic signed [31:0] sum;
    logic               ovf;
  } sat_t;

  function automatic sat_t sat_add(input int a, input int b, input int unsigned acc_w);
    int   lim;
    int   s;
    sat_t r;
    lim   = (1 << (acc_w - 1)) - 1;
    s     = a + b;
    r.ovf = 1'b1;
    if (s > lim) begin
      r.sum = lim;
    end else if (s < -lim) begin
      r.sum = -lim;
    end else begin
      r.sum = s;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  function automatic int unsigned period(input int unsigned mag, input int unsigned pmin,
                                         input int unsigned shift);
    int unsigned clip;
    clip = (mag > 255) ? 255 : mag;
    return pmin + ((255 - clip) << shift);
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: saturating pending-count accumulator, backlog-scaled
// step timer, quadrature phase and legacy dir/step_clk outputs.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int unsigned ACC_W        = 12,
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned PERIOD_MIN   = 3000,
  parameter int unsigned PERIOD_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                delta_valid,
  input  logic signed [ACC_W:0] scaled,
  input  logic                ovf_clr,
  output logic                quad_a,
  output logic                quad_b,
  output logic                dir,
  output logic                step_clk,
  output logic                busy,
  output logic                ovf
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [PERIOD_W-1:0]     cnt;
  logic [PERIOD_W-1:0]     cnt_next;
  logic [PERIOD_W-1:0]     period_cyc;
  logic [1:0]              phase;
  logic                    step;
  logic                    step_neg;
  logic                    clip;
  int                      acc_i;
  int                      adj;
  int unsigned             mag;
  sat_t                    sum;

  // A step and a new delta landing in the same cycle fold into one saturating add
  always_comb begin
    acc_i      = int'(acc);
    mag        = unsigned'((acc_i < 0) ? -acc_i : acc_i);
    period_cyc = PERIOD_W'(period(mag, PERIOD_MIN, PERIOD_SHIFT));
    step       = (acc != '0) && (cnt >= period_cyc);
    step_neg   = acc[ACC_W-1];
    adj        = step ? (step_neg ? 1 : -1) : 0;
    sum        = sat_add(acc_i + adj, delta_valid ? int'(scaled) : 0, ACC_W);
    acc_next   = ACC_W'(sum.sum);
    clip       = delta_valid && sum.ovf;
    cnt_next   = ((acc == '0) || step) ? '0 : cnt + PERIOD_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      phase    <= '0;
      dir      <= 1'b0;
      step_clk <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (clip) begin
        ovf <= 1'b1;
      end
      if (step) begin
        phase    <= step_neg ? phase - 2'd1 : phase + 2'd1;
        dir      <= step_neg;
        step_clk <= ~step_clk;
      end
    end
  end

  assign quad_a = GRAY_PHASE[phase][1];
  assign quad_b = GRAY_PHASE[phase][0];
  assign busy   = (acc != '0);

endmodule

// File: rtl/trackball_quad.sv
// Multi-axis trackball emulator top: slices and scales signed deltas per
// axis, applies per-axis flip, and fans out to one trackball_axis per axis.
module trackball_quad
  import trackball_pkg::*;
#(
  parameter int unsigned AXES         = 2,
  parameter int unsigned DELTA_W      = 8,
  parameter int unsigned ACC_W        = 12,
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned PERIOD_MIN   = 3000,
  parameter int unsigned PERIOD_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    delta_valid,
  input  logic [AXES*DELTA_W-1:0] delta,
  input  logic [1:0]              speed,
  input  logic [AXES-1:0]         flip,
  input  logic                    ovf_clr,
  output logic [AXES-1:0]         quad_a,
  output logic [AXES-1:0]         quad_b,
  output logic [AXES-1:0]         dir,
  output logic [AXES-1:0]         step_clk,
  output logic [AXES-1:0]         busy,
  output logic [AXES-1:0]         ovf
);

  logic signed [ACC_W:0]   scaled [AXES];
  logic signed [DELTA_W-1:0] d;
  logic [ACC_W:0]          mag;
  logic [ACC_W:0]          sh;
  int                      v;

  // Scale the magnitude and reapply the sign so rounding is toward zero
  always_comb begin
    d   = '0;
    mag = '0;
    sh  = '0;
    v   = 0;
    for (int unsigned i = 0; i < AXES; i++) begin
      d   = delta[i*DELTA_W +: DELTA_W];
      mag = d[DELTA_W-1] ? (ACC_W+1)'(-int'(d)) : (ACC_W+1)'(int'(d));
      unique case (speed)
        SPEED_QUARTER: sh = mag >> 2;
        SPEED_HALF:    sh = mag >> 1;
        SPEED_X1:      sh = mag;
        default:       sh = mag << 1;
      endcase
      v = d[DELTA_W-1] ? -int'(sh) : int'(sh);
      if (flip[i]) begin
        v = -v;
      end
      scaled[i] = (ACC_W+1)'(v);
    end
  end

  for (genvar g = 0; g < AXES; g++) begin : g_axis
    trackball_axis #(
      .ACC_W       (ACC_W),
      .PERIOD_W    (PERIOD_W),
      .PERIOD_MIN  (PERIOD_MIN),
      .PERIOD_SHIFT(PERIOD_SHIFT)
    ) u_axis (
      .clk        (clk),
      .reset      (reset),
      .delta_valid(delta_valid),
      .scaled     (scaled[g]),
      .ovf_clr    (ovf_clr),
      .quad_a     (quad_a[g]),
      .quad_b     (quad_b[g]),
      .dir        (dir[g]),
      .step_clk   (step_clk[g]),
      .busy       (busy[g]),
      .ovf        (ovf[g])
    );
  end

endmodule
